pipe_barrel_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the ALU datapath: the successor to the fixed 64-bit, combinational, left-logical shifter. It supports logical-left, logical-right, arithmetic-right and (optionally) rotate-left on a configurable power-of-two width. The log2(WIDTH) shift stages are divided into register groups with a valid/ready handshake and backpressure. A sideband tag travels alongside each operation so issue logic can match results to requests.

---
 rtl/pipe_barrel_shifter.sv | 140 ++++++++++++++
 tb/tb_pipe_barrel_shifter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready handshake and tag sideband.
// Define SHIFTER_ROTATE_EN to build rotate-left for op 11; otherwise op 11 acts as SLL.
module pipe_barrel_shifter #(
    parameter int WIDTH      = 64,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SHW = $clog2(WIDTH);
    localparam int L   = (SHW + PIPE_EVERY - 1) / PIPE_EVERY;

    logic [WIDTH-1:0] r_data  [L];
    logic [SHW-1:0]   r_shamt [L];
    logic [1:0]       r_op    [L];
    logic [TAG_W-1:0] r_tag   [L];
    logic             r_sign  [L];
    logic             r_valid [L];

    logic [WIDTH-1:0] w_res   [L];
    logic [SHW-1:0]   w_sh    [L];
    logic [1:0]       w_op    [L];
    logic [TAG_W-1:0] w_tag   [L];
    logic             w_sign  [L];
    logic             w_vin   [L];
    logic             w_adv   [L];

    // One mux level: shift d by s; SRA fills with the sign captured at accept
    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                     input logic [1:0] op,
                                                     input logic sign,
                                                     input int s);
        logic [WIDTH-1:0] fill;
        fill = sign ? ~({WIDTH{1'b1}} >> s) : {WIDTH{1'b0}};
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return (d >> s) | fill;
`ifdef SHIFTER_ROTATE_EN
            2'b11:   return (d << s) | (d >> (WIDTH - s));
`else
            2'b11:   return d << s;
`endif
            default: return d << s;
        endcase
    endfunction

    // Per-group source selection and the group's shift stages
    always_comb begin
        logic [WIDTH-1:0] d;
        int               gp;
        int               k;
        for (int g = 0; g < L; g++) begin
            gp = (g == 0) ? 0 : g - 1;
            if (g == 0) begin
                w_vin[g]  = in_valid;
                w_op[g]   = in_op;
                w_sh[g]   = in_shamt;
                w_sign[g] = in_data[WIDTH-1];
                w_tag[g]  = in_tag;
                d         = in_data;
            end else begin
                w_vin[g]  = r_valid[gp];
                w_op[g]   = r_op[gp];
                w_sh[g]   = r_shamt[gp];
                w_sign[g] = r_sign[gp];
                w_tag[g]  = r_tag[gp];
                d         = r_data[gp];
            end
            for (int j = 0; j < PIPE_EVERY; j++) begin
                k = g * PIPE_EVERY + j;
                if ((k < SHW) && (|(w_sh[g] & (SHW'(1) << k)))) begin
                    d = shift_stage(d, w_op[g], w_sign[g], 1 << k);
                end else begin
                    d = d;
                end
            end
            w_res[g] = d;
        end
    end

    // Advance chain: a group may load when empty or when its successor moves on
    always_comb begin
        logic adv;
        adv = 1'b0;
        for (int g = L - 1; g >= 0; g--) begin
            if (g == L - 1) begin
                adv = !r_valid[g] || out_ready;
            end else begin
                adv = !r_valid[g] || adv;
            end
            w_adv[g] = adv;
        end
    end

    assign in_ready  = !rst && w_adv[0];
    assign out_valid = r_valid[L-1];
    assign out_data  = r_data[L-1];
    assign out_tag   = r_tag[L-1];

    // Group registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < L; g++) begin
                r_valid[g] <= 1'b0;
                r_data[g]  <= {WIDTH{1'b0}};
                r_shamt[g] <= {SHW{1'b0}};
                r_op[g]    <= 2'b00;
                r_tag[g]   <= {TAG_W{1'b0}};
                r_sign[g]  <= 1'b0;
            end
        end else begin
            for (int g = 0; g < L; g++) begin
                if (w_adv[g]) begin
                    r_valid[g] <= w_vin[g];
                    if (w_vin[g]) begin
                        r_data[g]  <= w_res[g];
                        r_shamt[g] <= w_sh[g];
                        r_op[g]    <= w_op[g];
                        r_tag[g]   <= w_tag[g];
                        r_sign[g]  <= w_sign[g];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter (WIDTH=64, PIPE_EVERY=2, TAG_W=4).
module tb_pipe_barrel_shifter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_shamt;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_tag;

    int n_vec = 0;
    int n_err = 0;

    pipe_barrel_shifter #(.WIDTH(64), .PIPE_EVERY(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference: whole-word shift straight from the operation definitions
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh, input logic [1:0] op);
        case (op)
            2'd0:    return d << sh;
            2'd1:    return d >> sh;
            2'd2:    return $unsigned($signed(d) >>> sh);
`ifdef SHIFTER_ROTATE_EN
            2'd3:    return (d << sh) | (d >> (64 - sh));
`else
            2'd3:    return d << sh;
`endif
            default: return d;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [63:0] d, input logic [5:0] sh,
                         input logic [1:0] op, input logic [3:0] tg, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_shamt  = sh;
        in_op     = op;
        in_tag    = tg;
        out_ready = ordy;
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 64'd0, 6'd0, 2'd0, 4'd0, ordy);
    endtask

    task automatic run_single(input logic [1:0] op, input logic [63:0] d, input logic [5:0] sh,
                              input logic [3:0] tg, output logic [63:0] rd, output logic [3:0] rt,
                              output int lat);
        int tries;
        tries = 0;
        drive(1'b1, d, sh, op, tg, 1'b1);
        while (!in_ready && tries < 20) begin
            drive(1'b1, d, sh, op, tg, 1'b1);
            tries++;
        end
        rd  = 64'd0;
        rt  = 4'd0;
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            idle(1'b1);
            if (out_valid) begin
                rd  = out_data;
                rt  = out_tag;
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 64'hDEAD_BEEF_0000_1111, 6'd3, 2'd0, 4'd7, 1'b1);
        drive(1'b1, 64'hDEAD_BEEF_0000_1111, 6'd3, 2'd0, 4'd7, 1'b1);
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'd0 || out_tag !== 4'd0) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h out_tag=%h, want 0 0 0 0",
                     in_ready, out_valid, out_data, out_tag);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_sll();
        logic [63:0] rd;
        logic [3:0]  rt;
        int          lat;
        run_single(2'd0, 64'd1, 6'd63, 4'd5, rd, rt, lat);
        n_vec++;
        if (rd !== 64'h8000_0000_0000_0000 || rt !== 4'd5 || lat !== 3) begin
            n_err++;
            $display("FAIL sll_63: data=%h tag=%0d lat=%0d, want 8000000000000000 5 3", rd, rt, lat);
        end
    endtask

    task automatic test_right_shifts();
        logic [63:0] rd;
        logic [3:0]  rt;
        int          lat;
        run_single(2'd1, 64'h8000_0000_0000_0000, 6'd4, 4'd1, rd, rt, lat);
        n_vec++;
        if (rd !== 64'h0800_0000_0000_0000 || rt !== 4'd1 || lat !== 3) begin
            n_err++;
            $display("FAIL srl_4: data=%h tag=%0d lat=%0d, want 0800000000000000 1 3", rd, rt, lat);
        end
        run_single(2'd2, 64'h8000_0000_0000_0000, 6'd4, 4'd2, rd, rt, lat);
        n_vec++;
        if (rd !== 64'hF800_0000_0000_0000 || rt !== 4'd2 || lat !== 3) begin
            n_err++;
            $display("FAIL sra_4: data=%h tag=%0d lat=%0d, want f800000000000000 2 3", rd, rt, lat);
        end
    endtask

    task automatic test_rotate();
        logic [63:0] rd;
        logic [3:0]  rt;
        logic [63:0] want;
        int          lat;
`ifdef SHIFTER_ROTATE_EN
        want = 64'h0000_0000_0000_0003;
`else
        want = 64'h0000_0000_0000_0002;
`endif
        run_single(2'd3, 64'h8000_0000_0000_0001, 6'd1, 4'd9, rd, rt, lat);
        n_vec++;
        if (rd !== want || rt !== 4'd9) begin
            n_err++;
            $display("FAIL rol_1: data=%h tag=%0d, want %h 9", rd, rt, want);
        end
    endtask

    task automatic test_random_ops();
        logic [63:0] rd;
        logic [3:0]  rt;
        logic [63:0] d;
        logic [5:0]  sh;
        logic [1:0]  op;
        logic [3:0]  tg;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            d  = {$urandom, $urandom};
            sh = 6'($urandom_range(0, 63));
            op = 2'($urandom_range(0, 3));
            tg = 4'($urandom_range(0, 15));
            if (i < 4) sh = (i % 2 == 0) ? 6'd0 : 6'd63;
            run_single(op, d, sh, tg, rd, rt, lat);
            n_vec++;
            if (rd !== ref_shift(d, int'(sh), op) || rt !== tg || lat !== 3) begin
                n_err++;
                $display("FAIL random_op%0d: op=%0d sh=%0d d=%h got %h tag %0d lat %0d, want %h tag %0d lat 3",
                         i, op, sh, d, rd, rt, lat, ref_shift(d, int'(sh), op), tg);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] bd [6];
        logic [5:0]  bs [6];
        logic [1:0]  bo [6];
        logic [63:0] exp_d [$];
        logic [3:0]  exp_t [$];
        logic [63:0] held_d;
        logic [3:0]  held_t;
        logic        prev_stall;
        logic        ordy;
        logic        acc_now;
        int          acc;
        int          dlv;
        int          first_drop;
        for (int i = 0; i < 6; i++) begin
            bd[i] = {$urandom, $urandom};
            bs[i] = 6'($urandom_range(0, 63));
            bo[i] = 2'($urandom_range(0, 3));
        end
        acc = 0; dlv = 0; first_drop = -1; prev_stall = 1'b0;
        held_d = 64'd0; held_t = 4'd0;
        for (int c = 0; c < 40 && dlv < 6; c++) begin
            ordy = (c >= 8);
            if (acc < 6) drive(1'b1, bd[acc], bs[acc], bo[acc], 4'(acc), ordy);
            else         idle(ordy);
            acc_now = (acc < 6) && in_ready;
            if (acc < 6 && !in_ready && first_drop < 0) first_drop = acc;
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t) begin
                    n_err++;
                    $display("FAIL stall_hold c%0d: valid=%b data=%h tag=%0d, want 1 %h %0d",
                             c, out_valid, out_data, out_tag, held_d, held_t);
                end
            end
            if (out_valid && ordy) begin
                n_vec++;
                if (exp_d.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra: unexpected result data=%h tag=%0d", out_data, out_tag);
                end else begin
                    if (out_data !== exp_d[0] || out_tag !== exp_t[0]) begin
                        n_err++;
                        $display("FAIL bp_result%0d: data=%h tag=%0d, want %h %0d",
                                 dlv, out_data, out_tag, exp_d[0], exp_t[0]);
                    end
                    void'(exp_d.pop_front());
                    void'(exp_t.pop_front());
                end
                dlv++;
            end
            prev_stall = out_valid && !ordy;
            held_d = out_data;
            held_t = out_tag;
            if (acc_now) begin
                exp_d.push_back(ref_shift(bd[acc], int'(bs[acc]), bo[acc]));
                exp_t.push_back(4'(acc));
                acc++;
            end
        end
        n_vec++;
        if (first_drop !== 3) begin
            n_err++;
            $display("FAIL bp_capacity: accepted %0d before in_ready dropped, want 3", first_drop);
        end
        n_vec++;
        if (dlv !== 6) begin
            n_err++;
            $display("FAIL bp_delivered: %0d results, want 6", dlv);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d  [16];
        logic [1:0]  op [16];
        for (int i = 0; i < 16; i++) begin
            d[i]  = {$urandom, $urandom};
            op[i] = 2'($urandom_range(0, 3));
        end
        for (int c = 0; c < 20; c++) begin
            if (c < 16) drive(1'b1, d[c], 6'd0, op[c], 4'(c), 1'b1);
            else        idle(1'b1);
            if (c < 16) begin
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_ready c%0d: in_ready=%b want 1", c, in_ready);
                end
            end
            n_vec++;
            if (c >= 3 && c < 19) begin
                if (out_valid !== 1'b1 || out_data !== d[c-3] || out_tag !== 4'(c - 3)) begin
                    n_err++;
                    $display("FAIL b2b_out c%0d: valid=%b data=%h tag=%0d, want 1 %h %0d",
                             c, out_valid, out_data, out_tag, d[c-3], c - 3);
                end
            end else if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_bubble c%0d: out_valid=%b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd;
        logic [3:0]  rt;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {$urandom, $urandom}, 6'($urandom_range(0, 63)), 2'd1, 4'(i + 10), 1'b0);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL rst_fill%0d: in_ready=%b want 1", i, in_ready);
            end
        end
        idle(1'b0);
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_full: in_ready=%b out_valid=%b, want 0 1", in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || out_tag !== 4'd0) begin
            n_err++;
            $display("FAIL rst_flush: valid=%b data=%h tag=%0d, want 0 0 0", out_valid, out_data, out_tag);
        end
        for (int c = 0; c < 6; c++) begin
            idle(1'b1);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_stale c%0d: out_valid=%b want 0", c, out_valid);
            end
        end
        run_single(2'd2, 64'hF000_0000_0000_00F0, 6'd8, 4'd12, rd, rt, lat);
        n_vec++;
        if (rd !== 64'hFFF0_0000_0000_0000 || rt !== 4'd12 || lat !== 3) begin
            n_err++;
            $display("FAIL rst_after: data=%h tag=%0d lat=%0d, want fff0000000000000 12 3", rd, rt, lat);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 64'd0; in_shamt = 6'd0;
        in_op = 2'd0; in_tag = 4'd0; out_ready = 1'b0;
        test_reset();
        test_sll();
        test_right_shifts();
        test_rotate();
        test_random_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
